crypto_core: RTL and testbench

CRYPTO_CORE -- requirements
Module: crypto_core

---
 rtl/crypto_core.sv | 187 ++++++++++++++++++
 tb/tb_crypto_core.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_core.sv
// ============================================================================
// Module      : crypto_core
// Description : Multi-cycle 16-bit-instruction core with XOR/rotate ops and a
//               small resettable data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crypto_core #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [15:0]       retired,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ENC  = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_ILLD = 4'hD;
  localparam logic [3:0] OP_ILLE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [DATA_W-1:0] WIDTH_VAL = DATA_W'(DATA_W);
  localparam int                DMEM_D    = 1 << DMEM_AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t              state, state_nx;
  logic [PC_W-1:0]     pc;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   a_op, b_op, d_op;
  logic [DATA_W-1:0]   result;
  logic [DATA_W-1:0]   regs [16];
  logic [DATA_W-1:0]   dmem [DMEM_D];

  logic [3:0]          opcode, rd, rs1, rs2;
  logic [DATA_W-1:0]   alu_res, rot_amt, rol_res;
  logic [DMEM_AW-1:0]  mem_addr;
  logic [PC_W-1:0]     br_off, jmp_tgt;
  logic                retire_evt;

  assign opcode   = ir[15:12];
  assign rd       = ir[11:8];
  assign rs1      = ir[7:4];
  assign rs2      = ir[3:0];
  assign mem_addr = a_op[DMEM_AW-1:0];
  assign br_off   = PC_W'($signed(ir[7:0]));
  assign jmp_tgt  = PC_W'(ir[7:0]);

  assign imem_addr = pc;
  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign halted    = (state == S_HALT);
  assign dbg_data  = regs[dbg_sel];

  // A shift by the full width yields zero, so amount 0 needs no special case.
  assign rot_amt = b_op % WIDTH_VAL;
  assign rol_res = (a_op << rot_amt) | (a_op >> (WIDTH_VAL - rot_amt));

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:         alu_res = a_op + b_op;
      OP_SUB:         alu_res = a_op - b_op;
      OP_AND:         alu_res = a_op & b_op;
      OP_OR:          alu_res = a_op | b_op;
      OP_XOR, OP_ENC: alu_res = a_op ^ b_op;
      OP_LDI:         alu_res = DATA_W'(ir[7:0]);
      OP_ROL:         alu_res = rol_res;
      default:        alu_res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_LD, OP_ST:                                  state_nx = S_MEM;
          OP_HALT:                                       state_nx = S_HALT;
          OP_NOP, OP_BEQZ, OP_JMP, OP_ILLD, OP_ILLE:     state_nx = S_FETCH;
          default:                                       state_nx = S_WB;
        endcase
      end
      S_MEM:    state_nx = (opcode == OP_LD) ? S_WB : S_FETCH;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   if (start) state_nx = S_FETCH;
      default:  state_nx = S_IDLE;
    endcase
  end

  // HALT->FETCH restarts are not retirements; only completions are counted.
  assign retire_evt = ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) &&
                      (state_nx == S_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      a_op    <= '0;
      b_op    <= '0;
      d_op    <= '0;
      result  <= '0;
      illegal <= 1'b0;
      retired <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      for (int j = 0; j < DMEM_D; j++) dmem[j] <= '0;
    end else begin
      if (retire_evt && (retired != 16'hFFFF)) retired <= retired + 16'd1;
      case (state)
        S_FETCH: begin
          ir <= imem_data;
          pc <= pc + 1'b1;
        end
        S_DECODE: begin
          a_op <= regs[rs1];
          b_op <= regs[rs2];
          d_op <= regs[rd];
        end
        S_EXEC: begin
          result <= alu_res;
          // pc already points past the branch, so the offset is applied directly.
          if ((opcode == OP_BEQZ) && (d_op == '0)) pc <= pc + br_off;
          if (opcode == OP_JMP) pc <= jmp_tgt;
          if ((opcode == OP_ILLD) || (opcode == OP_ILLE)) illegal <= 1'b1;
        end
        S_MEM: begin
          if (opcode == OP_ST) dmem[mem_addr] <= b_op;
          else                 result <= dmem[mem_addr];
        end
        S_WB: begin
          if (rd != 4'd0) regs[rd] <= result;
        end
        S_HALT: begin
          if (start) begin
            pc      <= '0;
            illegal <= 1'b0;
            retired <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crypto_core.sv
// ============================================================================
// Module      : tb_crypto_core
// Description : Self-checking bench for crypto_core against an ISA-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crypto_core;

  localparam int DATA_W  = 8;
  localparam int PC_W    = 8;
  localparam int DMEM_AW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_data;
  logic              busy, halted, illegal;
  logic [15:0]       retired;
  logic [3:0]        dbg_sel = 4'd0;
  logic [DATA_W-1:0] dbg_data;

  logic [15:0] prog [256];
  assign imem_data = prog[imem_addr];

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_regs [16];
  logic [7:0] m_dmem [16];
  int         m_retired;
  bit         m_illegal;

  crypto_core #(.DATA_W(DATA_W), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] d,
                                      input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2};
  endfunction

  function automatic logic [15:0] enc_imm(input logic [3:0] op, input logic [3:0] d,
                                          input logic [7:0] imm);
    return {op, d, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
  endtask

  // Instruction-level interpretation of the ISA; no notion of pipeline states.
  task automatic model_run();
    int pc = 0;
    int steps = 0;
    bit done = 0;
    logic [15:0] w;
    logic [3:0] op, d, s1, s2;
    logic [7:0] a, b, r;
    bit wr;
    m_retired = 0;
    m_illegal = 0;
    while (!done && steps < 5000) begin
      w = prog[pc];
      op = w[15:12]; d = w[11:8]; s1 = w[7:4]; s2 = w[3:0];
      a = m_regs[s1]; b = m_regs[s2];
      wr = 0; r = 8'h00;
      pc = (pc + 1) % 256;
      steps++;
      case (op)
        4'h1: begin wr = 1; r = a + b; end
        4'h2: begin wr = 1; r = a - b; end
        4'h3: begin wr = 1; r = a & b; end
        4'h4: begin wr = 1; r = a | b; end
        4'h5, 4'h8: begin wr = 1; r = a ^ b; end
        4'h6: begin wr = 1; r = w[7:0]; end
        4'h7: begin wr = 1; r = m_dmem[a[3:0]]; end
        4'h9: m_dmem[a[3:0]] = b;
        4'hA: begin
          wr = 1; r = a;
          for (int k = 0; k < (b % 8); k++) r = {r[6:0], r[7]};
        end
        4'hB: if (m_regs[d] == 8'h00) pc = ((pc + int'($signed(w[7:0]))) % 256 + 256) % 256;
        4'hC: pc = int'(w[7:0]);
        4'hD, 4'hE: m_illegal = 1;
        4'hF: done = 1;
        default: ;
      endcase
      if (wr && d != 4'd0) m_regs[d] = r;
      if (!done) m_retired++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin m_regs[i] = 8'h00; m_dmem[i] = 8'h00; end
  endtask

  task automatic read_reg(input int i, output logic [7:0] v);
    dbg_sel = 4'(i);
    #1 v = dbg_data;
  endtask

  // Pulses start and counts rising edges after the sampling edge until halted.
  task automatic run(output int cycles, output bit timeout);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (!halted && cycles < 3000) begin
      @(posedge clk);
      #1 cycles++;
    end
    timeout = !halted;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b halted=%b illegal=%b required 0 0 0", busy, halted, illegal);
    end
    checks++;
    if (retired !== 16'h0 || imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_counters: retired=%h pc=%h required 0 0", retired, imem_addr);
    end
    for (int i = 0; i < 16; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg R%0d: got %h required 00", i, v);
      end
    end
  endtask

  task automatic test_enc();
    int cyc; bit to; logic [7:0] v;
    clear_prog();
    prog[0] = enc_imm(4'h6, 4'd1, 8'h3C);
    prog[1] = enc_imm(4'h6, 4'd2, 8'hA5);
    prog[2] = enc(4'h8, 4'd3, 4'd1, 4'd2);
    model_run();
    run(cyc, to);
    checks++;
    if (to || cyc != 15) begin
      failures++;
      $display("FAIL enc_halt_latency: edges=%0d timeout=%0d required 15", cyc, to);
    end
    read_reg(3, v);
    checks++;
    if (v !== m_regs[3] || v !== 8'h99) begin
      failures++;
      $display("FAIL enc_r3: got %h required %h", v, m_regs[3]);
    end
    checks++;
    if (retired !== 16'(m_retired)) begin
      failures++;
      $display("FAIL enc_retired: got %0d required %0d", retired, m_retired);
    end
  endtask

  // Runs the loaded program and compares every register and the flags.
  task automatic run_and_compare(input string name);
    int cyc; bit to; logic [7:0] v;
    model_run();
    run(cyc, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL %s_timeout: halted=%b after %0d edges required 1", name, halted, cyc);
    end
    for (int i = 0; i < 16; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== m_regs[i]) begin
        failures++;
        $display("FAIL %s_R%0d: got %h required %h", name, i, v, m_regs[i]);
      end
    end
    checks++;
    if (retired !== 16'(m_retired) || illegal !== m_illegal) begin
      failures++;
      $display("FAIL %s_status: retired=%0d illegal=%b required %0d %b",
               name, retired, illegal, m_retired, m_illegal);
    end
  endtask

  task automatic test_arith();
    clear_prog();
    prog[0] = enc_imm(4'h6, 4'd5, 8'h01);
    prog[1] = enc_imm(4'h6, 4'd1, 8'hF0);
    prog[2] = enc_imm(4'h6, 4'd2, 8'h20);
    prog[3] = enc(4'h1, 4'd3, 4'd1, 4'd2);
    prog[4] = enc(4'h2, 4'd4, 4'd0, 4'd5);
    run_and_compare("arith");
    checks++;
    if (m_regs[3] !== 8'h10 || m_regs[4] !== 8'hFF) begin
      failures++;
      $display("FAIL arith_expect: model R3=%h R4=%h required 10 FF", m_regs[3], m_regs[4]);
    end
  endtask

  task automatic test_mem();
    clear_prog();
    prog[0] = enc_imm(4'h6, 4'd1, 8'h13);
    prog[1] = enc_imm(4'h6, 4'd2, 8'h5A);
    prog[2] = enc(4'h9, 4'd0, 4'd1, 4'd2);
    prog[3] = enc_imm(4'h6, 4'd6, 8'h03);
    prog[4] = enc(4'h7, 4'd4, 4'd6, 4'd0);
    run_and_compare("mem");
  endtask

  task automatic test_branch();
    logic [7:0] v;
    clear_prog();
    prog[0] = enc_imm(4'h6, 4'd1, 8'h03);
    prog[1] = enc_imm(4'h6, 4'd2, 8'h01);
    prog[2] = enc(4'h2, 4'd1, 4'd1, 4'd2);
    prog[3] = enc_imm(4'hB, 4'd1, 8'h01);
    prog[4] = enc_imm(4'hC, 4'd0, 8'h02);
    run_and_compare("branch");
    read_reg(1, v);
    checks++;
    if (v !== 8'h00 || halted !== 1'b1) begin
      failures++;
      $display("FAIL branch_exit: R1=%h halted=%b required 00 1", v, halted);
    end
  endtask

  task automatic test_illegal();
    int cyc; bit to;
    clear_prog();
    prog[0] = enc_imm(4'h6, 4'd0, 8'h77);
    prog[1] = 16'hD123;
    run_and_compare("illegal");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (illegal !== 1'b0 || retired !== 16'h0 || imem_addr !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear: illegal=%b retired=%0d pc=%h busy=%b required 0 0 00 1",
               illegal, retired, imem_addr, busy);
    end
    cyc = 0;
    while (!halted && cyc < 3000) begin @(posedge clk); #1 cyc++; end
    to = !halted;
    checks++;
    if (to || retired !== 16'd2 || illegal !== 1'b1) begin
      failures++;
      $display("FAIL restart_rerun: timeout=%0d retired=%0d illegal=%b required 0 2 1", to, retired, illegal);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v1, v3;
    clear_prog();
    prog[0] = enc_imm(4'h6, 4'd1, 8'h05);
    prog[1] = enc_imm(4'h6, 4'd2, 8'h07);
    prog[2] = enc(4'h1, 4'd3, 4'd1, 4'd2);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || retired !== 16'd2) begin
      failures++;
      $display("FAIL mid_pre: busy=%b retired=%0d required 1 2", busy, retired);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin m_regs[i] = 8'h00; m_dmem[i] = 8'h00; end
    read_reg(3, v3);
    read_reg(1, v1);
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || retired !== 16'h0 || imem_addr !== 8'h00 ||
        v3 !== 8'h00 || v1 !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset: busy=%b halted=%b retired=%0d pc=%h R1=%h R3=%h required 0 0 0 00 00 00",
               busy, halted, retired, imem_addr, v1, v3);
    end
  endtask

  task automatic test_start_busy();
    int cyc; logic [7:0] v;
    clear_prog();
    prog[0] = enc_imm(4'h6, 4'd1, 8'h21);
    prog[1] = enc_imm(4'h6, 4'd2, 8'h0E);
    prog[2] = enc(4'h1, 4'd3, 4'd1, 4'd2);
    prog[3] = enc(4'hA, 4'd4, 4'd3, 4'd2);
    model_run();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 start = (k % 3 == 0);
    end
    start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 3000) begin @(posedge clk); #1 cyc++; end
    checks++;
    if (!halted || retired !== 16'(m_retired)) begin
      failures++;
      $display("FAIL busy_start_status: halted=%b retired=%0d required 1 %0d", halted, retired, m_retired);
    end
    for (int i = 1; i < 5; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== m_regs[i]) begin
        failures++;
        $display("FAIL busy_start_R%0d: got %h required %h", i, v, m_regs[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int p = 0; p < 5; p++) begin
      clear_prog();
      for (int i = 0; i < 6; i++)
        prog[i] = enc_imm(4'h6, 4'($urandom_range(1, 15)), 8'($urandom));
      for (int i = 6; i < 30; i++) begin
        op = 4'($urandom_range(0, 14));
        if (op == 4'hC) op = 4'h6;
        if (op == 4'hB)
          prog[i] = enc_imm(op, 4'($urandom), 8'($urandom_range(0, 3)));
        else
          prog[i] = {op, 12'($urandom)};
      end
      run_and_compare($sformatf("random%0d", p));
    end
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_enc();
    test_arith();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_start_busy();
    test_random();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
